// File: rtl/lc2k_pkg.sv
// Shared LC-2K definitions: opcodes, ALU op codes, instruction field positions
// and the ID/EX control bundle consumed by the execute stage.
package lc2k_pkg;

    localparam int LC2K_XLEN  = 32;
    localparam int LC2K_NREGS = 8;
    localparam int LC2K_RIDX  = 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_NOOP = 3'b111;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_NOR = 2'b01,
        ALU_EQ  = 2'b10
    } alu_op_e;

    localparam int OPC_HI  = 24;
    localparam int OPC_LO  = 22;
    localparam int RA_HI   = 21;
    localparam int RA_LO   = 19;
    localparam int RB_HI   = 18;
    localparam int RB_LO   = 16;
    localparam int DEST_HI = 2;
    localparam int DEST_LO = 0;
    localparam int OFF_HI  = 15;
    localparam int OFF_LO  = 0;

    // All-zero value of this struct is a bubble.
    typedef struct packed {
        logic    valid;
        alu_op_e alu_op;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    is_beq;
        logic    is_jalr;
        logic    is_halt;
    } idex_ctrl_t;

    function automatic logic [LC2K_XLEN-1:0] sext16(input logic [15:0] v);
        return {{(LC2K_XLEN-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/lc2k_regfile.sv
// 8-entry architectural register file: two combinational read ports that see a
// same-cycle writeback, one synchronous write port, R0 fixed at zero.
module lc2k_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            we_i,
    input  logic [AW-1:0]   wreg_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [AW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wreg_i != '0)) begin
            regs_q[wreg_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i != '0) begin
            rdata_a_o = (we_i && (wreg_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
        end
    end

    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i != '0) begin
            rdata_b_o = (we_i && (wreg_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/lc2k_decode_stage.sv
// LC-2K decode/register-read stage: decodes the fetched word, reads operands,
// stalls on load-use, and loads the ID/EX register (bubbles on flush/halt/stall).
module lc2k_decode_stage
    import lc2k_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ifValid,
    input  logic [31:0]     ifInstr,
    input  logic [XLEN-1:0] ifPC,
    output logic            idReady,
    input  logic            flush,
    input  logic            wbEnable,
    input  logic [AW-1:0]   wbReg,
    input  logic [XLEN-1:0] wbData,
    output logic            exValid,
    output logic [XLEN-1:0] aluValA,
    output logic [XLEN-1:0] aluValB,
    output logic [1:0]      CONTROL_OPERATION,
    output logic [XLEN-1:0] exStoreData,
    output logic [XLEN-1:0] exOffset,
    output logic [AW-1:0]   exDest,
    output logic            exRegWrite,
    output logic            exMemRead,
    output logic            exMemWrite,
    output logic            exIsBeq,
    output logic            exIsJalr,
    output logic            exIsHalt,
    output logic [XLEN-1:0] exPC
);

    logic [2:0]      opcode;
    logic [AW-1:0]   reg_a, reg_b, dest_f;
    logic [XLEN-1:0] offset_sx;
    logic [XLEN-1:0] rd_a, rd_b;
    logic            uses_a, uses_b;
    logic            load_use;
    logic            issue;

    idex_ctrl_t      ctrl_d, ctrl_q;
    logic [XLEN-1:0] val_a_d, val_a_q;
    logic [XLEN-1:0] val_b_d, val_b_q;
    logic [XLEN-1:0] store_d, store_q;
    logic [XLEN-1:0] off_d, off_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [AW-1:0]   dest_d, dest_q;
    logic            halted_d, halted_q;

    assign opcode    = ifInstr[OPC_HI:OPC_LO];
    assign reg_a     = ifInstr[RA_HI:RA_LO];
    assign reg_b     = ifInstr[RB_HI:RB_LO];
    assign dest_f    = ifInstr[DEST_HI:DEST_LO];
    assign offset_sx = sext16(ifInstr[OFF_HI:OFF_LO]);

    lc2k_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk       (clk),
        .resetn    (resetn),
        .we_i      (wbEnable),
        .wreg_i    (wbReg),
        .wdata_i   (wbData),
        .raddr_a_i (reg_a),
        .rdata_a_o (rd_a),
        .raddr_b_i (reg_b),
        .rdata_b_o (rd_b)
    );

    always_comb begin
        uses_a = !((opcode == OP_HALT) || (opcode == OP_NOOP));
        uses_b = (opcode == OP_ADD) || (opcode == OP_NOR) ||
                 (opcode == OP_BEQ) || (opcode == OP_SW);
    end

    // Only register indices feed the hazard check, so wbData never reaches idReady.
    assign load_use = ifValid && ctrl_q.valid && ctrl_q.mem_read && (dest_q != '0) &&
                      ((uses_a && (reg_a == dest_q)) || (uses_b && (reg_b == dest_q)));

    assign issue   = ifValid && !flush && !halted_q && !load_use;
    assign idReady = flush || (!halted_q && !load_use);

    always_comb begin
        ctrl_d  = '0;
        val_a_d = '0;
        val_b_d = '0;
        store_d = '0;
        off_d   = '0;
        pc_d    = '0;
        dest_d  = '0;
        if (issue) begin
            ctrl_d.valid = 1'b1;
            off_d        = offset_sx;
            pc_d         = ifPC;
            val_a_d      = rd_a;
            store_d      = rd_b;
            case (opcode)
                OP_ADD, OP_NOR: begin
                    val_b_d          = rd_b;
                    ctrl_d.alu_op    = (opcode == OP_NOR) ? ALU_NOR : ALU_ADD;
                    dest_d           = dest_f;
                    ctrl_d.reg_write = 1'b1;
                end
                OP_LW: begin
                    val_b_d          = offset_sx;
                    dest_d           = reg_b;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.mem_read  = 1'b1;
                end
                OP_SW: begin
                    val_b_d          = offset_sx;
                    ctrl_d.mem_write = 1'b1;
                end
                OP_BEQ: begin
                    val_b_d       = rd_b;
                    ctrl_d.alu_op = ALU_EQ;
                    ctrl_d.is_beq = 1'b1;
                end
                OP_JALR: begin
                    dest_d           = reg_b;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.is_jalr   = 1'b1;
                end
                OP_HALT: begin
                    ctrl_d.is_halt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Once a halt enters ID/EX, only reset leaves the halted condition.
    assign halted_d = halted_q || (issue && (opcode == OP_HALT));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_q   <= '0;
            val_a_q  <= '0;
            val_b_q  <= '0;
            store_q  <= '0;
            off_q    <= '0;
            pc_q     <= '0;
            dest_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            val_a_q  <= val_a_d;
            val_b_q  <= val_b_d;
            store_q  <= store_d;
            off_q    <= off_d;
            pc_q     <= pc_d;
            dest_q   <= dest_d;
            halted_q <= halted_d;
        end
    end

    assign exValid           = ctrl_q.valid;
    assign aluValA           = val_a_q;
    assign aluValB           = val_b_q;
    assign CONTROL_OPERATION = ctrl_q.alu_op;
    assign exStoreData       = store_q;
    assign exOffset          = off_q;
    assign exDest            = dest_q;
    assign exRegWrite        = ctrl_q.reg_write;
    assign exMemRead         = ctrl_q.mem_read;
    assign exMemWrite        = ctrl_q.mem_write;
    assign exIsBeq           = ctrl_q.is_beq;
    assign exIsJalr          = ctrl_q.is_jalr;
    assign exIsHalt          = ctrl_q.is_halt;
    assign exPC              = pc_q;

endmodule
